// File: rtl/aes_pkg.sv
// aes_pkg: S-box tables, byte indexing and FSM encoding shared by the AES round stages
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, CAPT} state_e;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  function automatic int byte_off(input int c, input int r);
    return 8 * (4 * c + r);
  endfunction
endpackage

// File: rtl/aes_sbox_bram.sv
// aes_sbox_bram: 256x8 dual-port synchronous S-box ROM with one-cycle read latency
module aes_sbox_bram
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic       clk,
  input  logic [7:0] addr_a_i,
  input  logic [7:0] addr_b_i,
  output logic [7:0] dout_a_o,
  output logic [7:0] dout_b_o
);
  logic [7:0] dout_a_q, dout_b_q;
  always_ff @(posedge clk) begin
    dout_a_q <= INV ? INV_SBOX[addr_a_i] : SBOX[addr_a_i];
    dout_b_q <= INV ? INV_SBOX[addr_b_i] : SBOX[addr_b_i];
  end
  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;
endmodule

// File: rtl/aes_128_subshift.sv
// aes_128_subshift: SubBytes + ShiftRows stage of the iterative AES-128 round, one block per 3 cycles
module aes_128_subshift
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_last
);
  state_e       state_q, state_d;
  logic [127:0] hold_q, hold_d, out_data_q, out_data_d;
  logic [63:0]  lo_q, lo_d, half, sub;
  logic         last_q, last_d, out_last_q, out_last_d, out_valid_q, out_valid_d, accept;

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[byte_off(c, r) +: 8] = s[byte_off(INV ? (c + 4 - r) % 4 : (c + r) % 4, r) +: 8];
    return y;
  endfunction

  // Each ROM serves two adjacent bytes of the current 64-bit half
  for (genvar k = 0; k < 4; k++) begin : g_rom
    aes_sbox_bram #(.INV(INV)) u_rom (
      .clk      (clk),
      .addr_a_i (half[16*k +: 8]),
      .addr_b_i (half[16*k+8 +: 8]),
      .dout_a_o (sub[16*k +: 8]),
      .dout_b_o (sub[16*k+8 +: 8])
    );
  end

  assign in_ready = !kill && (state_q == IDLE || state_q == CAPT);

  always_comb begin
    accept      = in_valid && in_ready;
    half        = state_q == RD_HI ? hold_q[127:64] : hold_q[63:0];
    state_d     = state_q == RD_LO ? RD_HI : state_q == RD_HI ? CAPT : accept ? RD_LO : IDLE;
    hold_d      = accept ? in_data : hold_q;
    last_d      = accept ? in_last : last_q;
    lo_d        = state_q == RD_HI ? sub : lo_q;
    out_valid_d = state_q == CAPT;
    out_data_d  = out_valid_d ? shift_rows({sub, lo_q}) : out_data_q;
    out_last_d  = out_valid_d ? last_q : out_last_q;
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      last_q      <= 1'b0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_aes_128_subshift.sv
// tb_aes_128_subshift: encrypt and decrypt instances checked against a GF(2^8) arithmetic model
module tb_aes_128_subshift;
  logic clk = 1'b0, kill = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [127:0] in_data = '0;
  logic enc_ready, enc_valid, enc_last, dec_ready, dec_valid, dec_last;
  logic [127:0] enc_data, dec_data;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] fwd [256];
  logic [7:0] inv [256];
  typedef struct {
    logic [127:0] enc;
    logic [127:0] dec;
    logic         last;
    int           due;
  } exp_t;
  exp_t q[$];
  logic [127:0] held_enc = '0, held_dec = '0, kat_enc = '0, kat_dec = '0;
  logic held_last = 1'b0, kat_use_enc = 1'b0, kat_use_dec = 1'b0;
  bit exp_v, exp_r;

  aes_128_subshift #(.INV(1'b0)) dut_enc (
    .clk(clk), .kill(kill), .in_valid(in_valid), .in_ready(enc_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(enc_valid), .out_data(enc_data), .out_last(enc_last)
  );
  aes_128_subshift #(.INV(1'b1)) dut_dec (
    .clk(clk), .kill(kill), .in_valid(in_valid), .in_ready(dec_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(dec_valid), .out_data(dec_data), .out_last(dec_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input bit dir);
    logic [7:0] s [16];
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) s[i] = dir ? inv[d[8*i +: 8]] : fwd[d[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[8*(4*c + r) +: 8] = s[4 * (((dir ? c - r : c + r) % 4 + 4) % 4) + r];
    return y;
  endfunction

  // Scoreboard: every cycle checks pulse timing, held outputs and ready against the queue
  always @(negedge clk) begin
    exp_t e;
    exp_v = q.size() > 0 && q[0].due == cyc;
    if (exp_v) begin
      e = q.pop_front();
      held_enc = e.enc;
      held_dec = e.dec;
      held_last = e.last;
    end
    check("enc_valid", 128'(enc_valid), 128'(exp_v));
    check("dec_valid", 128'(dec_valid), 128'(exp_v));
    check("enc_data", enc_data, held_enc);
    check("dec_data", dec_data, held_dec);
    check("enc_last", 128'(enc_last), 128'(held_last));
    check("dec_last", 128'(dec_last), 128'(held_last));
    exp_r = !kill && (q.size() == 0 || q[0].due == cyc + 1);
    check("enc_ready", 128'(enc_ready), 128'(exp_r));
    check("dec_ready", 128'(dec_ready), 128'(exp_r));
    if (kill) begin
      q.delete();
      held_enc = '0;
      held_dec = '0;
      held_last = 1'b0;
    end else if (in_valid && exp_r)
      q.push_back('{kat_use_enc ? kat_enc : model(in_data, 1'b0),
                    kat_use_dec ? kat_dec : model(in_data, 1'b1), in_last, cyc + 4});
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int t;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    for (t = 0; t < 8 && !enc_ready; t++) begin
      @(posedge clk);
      #1;
    end
    check("accept_wait", 128'(t < 8), 128'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] d;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, s;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
      fwd[x] = s;
      inv[s] = 8'(x);
    end
    repeat (2) @(posedge clk);
    #1;
    kill = 1'b0;
    idle(1);
    kat_use_enc = 1'b1;
    kat_enc = {16{8'h63}};
    send('0, 1'b0);
    kat_use_enc = 1'b0;
    idle(4);
    kat_use_enc = 1'b1;
    kat_enc = 128'he598271ef11141b8ae52b4e0305dbfd4;
    send(128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b1);
    kat_use_enc = 1'b0;
    idle(4);
    kat_use_dec = 1'b1;
    kat_dec = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    send(128'he598271ef11141b8ae52b4e0305dbfd4, 1'b0);
    kat_use_dec = 1'b0;
    idle(4);
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'(i));
    idle(5);
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle(1);
    kill = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    in_valid = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    idle(5);
    for (int i = 0; i < 200; i++) begin
      int r;
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'($urandom_range(0, 1)));
      r = $urandom_range(0, 5);
      if (r == 0) begin
        idle($urandom_range(0, 3));
        kill = 1'b1;
        idle(1);
        kill = 1'b0;
      end else if (r > 2) idle($urandom_range(0, 4));
    end
    idle(6);
    check("drain", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
